// File: rtl/apb_intr_host_pkg.sv
// Shared state encodings and bus widths for the APB interrupt host.
package apb_intr_host_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned ID_W   = 4;

  typedef enum logic [1:0] {
    A_IDLE,
    A_SETUP,
    A_ACCESS,
    A_RESP
  } apb_state_e;

  typedef enum logic [1:0] {
    I_IDLE,
    I_SERVICE,
    I_ACK,
    I_DRAIN
  } intr_state_e;

endpackage

// File: rtl/apb_intr_host_if.sv
// Command/response stream plus APB initiator signals; master is the host side.
interface apb_intr_host_if;
  import apb_intr_host_pkg::*;

  logic              cmd_valid_i;
  logic              cmd_ready_o;
  logic              cmd_write_i;
  logic [ADDR_W-1:0] cmd_addr_i;
  logic [DATA_W-1:0] cmd_wdata_i;
  logic              rsp_valid_o;
  logic [DATA_W-1:0] rsp_rdata_o;
  logic              rsp_error_o;
  logic [ADDR_W-1:0] paddr_o;
  logic [DATA_W-1:0] pwdata_o;
  logic              pwrite_o;
  logic              psel_o;
  logic              penable_o;
  logic [DATA_W-1:0] prdata_i;
  logic              pready_i;
  logic              perror_i;

  modport master (
    input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i,
           prdata_i, pready_i, perror_i,
    output cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_error_o,
           paddr_o, pwdata_o, pwrite_o, psel_o, penable_o
  );

  modport slave (
    output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i,
           prdata_i, pready_i, perror_i,
    input  cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_error_o,
           paddr_o, pwdata_o, pwrite_o, psel_o, penable_o
  );

endinterface

// File: rtl/apb_intr_host_apb_master_fsm.sv
// APB initiator: one outstanding command, SETUP/ACCESS/RESP sequencing with
// an ACCESS-phase timeout. Every output is a register.
module apb_master_fsm
  import apb_intr_host_pkg::*;
#(
  parameter int unsigned APB_TIMEOUT = 15
) (
  input  logic            pclk_i,
  input  logic            prst_i,
  apb_intr_host_if.master bus
);

  // Counter holds completed ACCESS cycles, so the last allowed cycle sees TIMEOUT-1.
  localparam logic [7:0] TMO_LAST = 8'(APB_TIMEOUT - 1);

  apb_state_e        r_state;
  logic [7:0]        r_tmo;
  logic              r_cmd_ready;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_error;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;
  logic              r_pwrite;
  logic              r_psel;
  logic              r_penable;

  always_ff @(posedge pclk_i or posedge prst_i) begin
    if (prst_i) begin
      r_state     <= A_IDLE;
      r_tmo       <= '0;
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_error <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_pwrite    <= 1'b0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
    end else begin
      case (r_state)
        A_IDLE: begin
          if (bus.cmd_valid_i && r_cmd_ready) begin
            r_paddr     <= bus.cmd_addr_i;
            r_pwdata    <= bus.cmd_wdata_i;
            r_pwrite    <= bus.cmd_write_i;
            r_psel      <= 1'b1;
            r_cmd_ready <= 1'b0;
            r_state     <= A_SETUP;
          end else begin
            r_cmd_ready <= 1'b1;
          end
        end
        A_SETUP: begin
          r_penable <= 1'b1;
          r_tmo     <= '0;
          r_state   <= A_ACCESS;
        end
        A_ACCESS: begin
          r_tmo <= r_tmo + 8'd1;
          if (bus.pready_i) begin
            r_rsp_error <= bus.perror_i;
            r_rsp_rdata <= (!r_pwrite && !bus.perror_i) ? bus.prdata_i : '0;
            r_rsp_valid <= 1'b1;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_state     <= A_RESP;
          end else if (r_tmo == TMO_LAST) begin
            r_rsp_error <= 1'b1;
            r_rsp_rdata <= '0;
            r_rsp_valid <= 1'b1;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_state     <= A_RESP;
          end
        end
        A_RESP: begin
          r_rsp_valid <= 1'b0;
          r_rsp_error <= 1'b0;
          r_rsp_rdata <= '0;
          r_cmd_ready <= 1'b1;
          r_state     <= A_IDLE;
        end
        default: r_state <= A_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready_o = r_cmd_ready;
  assign bus.rsp_valid_o = r_rsp_valid;
  assign bus.rsp_rdata_o = r_rsp_rdata;
  assign bus.rsp_error_o = r_rsp_error;
  assign bus.paddr_o     = r_paddr;
  assign bus.pwdata_o    = r_pwdata;
  assign bus.pwrite_o    = r_pwrite;
  assign bus.psel_o      = r_psel;
  assign bus.penable_o   = r_penable;

endmodule

// File: rtl/apb_intr_host.sv
// Processor-side host: APB initiator for priority programming plus an
// independent fixed-length interrupt responder.
module apb_intr_host
  import apb_intr_host_pkg::*;
#(
  parameter int unsigned NUM_INTR    = 16,
  parameter int unsigned SVC_CYCLES  = 4,
  parameter int unsigned APB_TIMEOUT = 15
) (
  input  logic                        pclk_i,
  input  logic                        prst_i,
  apb_intr_host_if.master             bus,
  input  logic                        intr_valid_i,
  input  logic [$clog2(NUM_INTR)-1:0] intr_to_service_i,
  output logic                        intr_serviced_o,
  output logic [$clog2(NUM_INTR)-1:0] svc_id_o,
  output logic                        svc_busy_o,
  output logic [15:0]                 svc_count_o
);

  localparam int unsigned IDW      = $clog2(NUM_INTR);
  localparam logic [7:0]  SVC_LOAD = 8'(SVC_CYCLES);

  apb_master_fsm #(
    .APB_TIMEOUT(APB_TIMEOUT)
  ) u_apb (
    .pclk_i(pclk_i),
    .prst_i(prst_i),
    .bus   (bus)
  );

  intr_state_e    r_istate;
  logic [7:0]     r_svc_cnt;
  logic [IDW-1:0] r_svc_id;
  logic           r_busy;
  logic           r_serviced;
  logic [15:0]    r_count;

  // The acknowledge is registered on leaving I_ACK, so it lands in the first
  // I_DRAIN cycle; I_DRAIN then blocks a still-held request from re-triggering.
  always_ff @(posedge pclk_i or posedge prst_i) begin
    if (prst_i) begin
      r_istate   <= I_IDLE;
      r_svc_cnt  <= '0;
      r_svc_id   <= '0;
      r_busy     <= 1'b0;
      r_serviced <= 1'b0;
      r_count    <= '0;
    end else begin
      case (r_istate)
        I_IDLE: begin
          r_serviced <= 1'b0;
          if (intr_valid_i) begin
            r_svc_id  <= intr_to_service_i;
            r_busy    <= 1'b1;
            r_svc_cnt <= SVC_LOAD;
            r_istate  <= I_SERVICE;
          end
        end
        I_SERVICE: begin
          if (r_svc_cnt <= 8'd1) begin
            r_istate <= I_ACK;
          end else begin
            r_svc_cnt <= r_svc_cnt - 8'd1;
          end
        end
        I_ACK: begin
          r_serviced <= 1'b1;
          r_busy     <= 1'b0;
          if (r_count != '1) begin
            r_count <= r_count + 16'd1;
          end
          r_istate <= I_DRAIN;
        end
        I_DRAIN: begin
          r_serviced <= 1'b0;
          if (!intr_valid_i) begin
            r_istate <= I_IDLE;
          end
        end
        default: r_istate <= I_IDLE;
      endcase
    end
  end

  assign intr_serviced_o = r_serviced;
  assign svc_id_o        = r_svc_id;
  assign svc_busy_o      = r_busy;
  assign svc_count_o     = r_count;

endmodule

// File: tb/tb_apb_intr_host.sv
// Directed bench for apb_intr_host: APB write/read/error/timeout, interrupt
// service timing and hold-off, concurrent operation and mid-operation reset.
module tb_apb_intr_host;

  logic        clk;
  logic        rst;
  logic        intr_valid;
  logic [3:0]  intr_id;
  logic        intr_serviced;
  logic [3:0]  svc_id;
  logic        svc_busy;
  logic [15:0] svc_count;

  logic        slv_hang;
  logic [7:0]  slv_rdata;
  logic        slv_err;

  int unsigned n_pass;
  int unsigned n_total;

  apb_intr_host_if bus();

  apb_intr_host #(
    .NUM_INTR   (16),
    .SVC_CYCLES (4),
    .APB_TIMEOUT(15)
  ) dut (
    .pclk_i           (clk),
    .prst_i           (rst),
    .bus              (bus),
    .intr_valid_i     (intr_valid),
    .intr_to_service_i(intr_id),
    .intr_serviced_o  (intr_serviced),
    .svc_id_o         (svc_id),
    .svc_busy_o       (svc_busy),
    .svc_count_o      (svc_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave that registers pready one cycle after seeing penable.
  always @(posedge clk or posedge rst) begin
    if (rst) bus.pready_i <= 1'b0;
    else     bus.pready_i <= !slv_hang && bus.psel_o && bus.penable_o && !bus.pready_i;
  end
  assign bus.prdata_i = slv_rdata;
  assign bus.perror_i = slv_err && bus.pready_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drives one command from a negedge and returns at the negedge showing rsp_valid.
  task automatic do_cmd(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                        output int unsigned wait_cyc, output int unsigned lat,
                        output int unsigned nsel, output int unsigned nen,
                        output logic [7:0] rdata, output logic err,
                        output logic got, output logic bus_ok);
    wait_cyc = 0; lat = 0; nsel = 0; nen = 0;
    rdata = '0; err = 1'b0; got = 1'b0; bus_ok = 1'b1;
    bus.cmd_valid_i = 1'b1;
    bus.cmd_write_i = wr;
    bus.cmd_addr_i  = addr;
    bus.cmd_wdata_i = wdata;
    while (!bus.cmd_ready_o && wait_cyc < 50) begin
      @(negedge clk);
      wait_cyc++;
    end
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    lat = 1;
    while (lat < 40) begin
      if (bus.psel_o) begin
        nsel++;
        if (bus.paddr_o !== addr || bus.pwdata_o !== wdata || bus.pwrite_o !== wr) bus_ok = 1'b0;
      end
      if (bus.penable_o) nen++;
      if (bus.rsp_valid_o) begin
        got   = 1'b1;
        rdata = bus.rsp_rdata_o;
        err   = bus.rsp_error_o;
        break;
      end
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    n_total++; if (bus.cmd_ready_o !== 1'b0) $display("FAIL reset_cmd_ready: got %0b exp 0", bus.cmd_ready_o); else n_pass++;
    n_total++; if ({bus.psel_o, bus.penable_o, bus.rsp_valid_o} !== 3'b000)
      $display("FAIL reset_apb_ctl: got %03b exp 000", {bus.psel_o, bus.penable_o, bus.rsp_valid_o}); else n_pass++;
    n_total++; if ({intr_serviced, svc_busy, svc_id} !== 6'd0)
      $display("FAIL reset_intr: got %0h exp 0", {intr_serviced, svc_busy, svc_id}); else n_pass++;
    n_total++; if (svc_count !== 16'd0) $display("FAIL reset_count: got %0h exp 0", svc_count); else n_pass++;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_total++; if (bus.cmd_ready_o !== 1'b1) $display("FAIL ready_after_reset: got %0b exp 1", bus.cmd_ready_o); else n_pass++;
  endtask

  task automatic test_write();
    int unsigned w, l, s, e; logic [7:0] rd; logic er, g, ok;
    do_cmd(1'b1, 8'h03, 8'h0A, w, l, s, e, rd, er, g, ok);
    n_total++; if (g !== 1'b1) $display("FAIL wr_rsp_seen: got %0b exp 1", g); else n_pass++;
    n_total++; if ({er, rd} !== 9'd0) $display("FAIL wr_err_rdata: got %0h exp 0", {er, rd}); else n_pass++;
    n_total++; if (s !== 3) $display("FAIL wr_psel_cycles: got %0d exp 3", s); else n_pass++;
    n_total++; if (e !== 2) $display("FAIL wr_penable_cycles: got %0d exp 2", e); else n_pass++;
    n_total++; if (l !== 4) $display("FAIL wr_latency: got %0d exp 4", l); else n_pass++;
    n_total++; if (ok !== 1'b1) $display("FAIL wr_bus_stable: got %0b exp 1", ok); else n_pass++;
    @(negedge clk);
    n_total++; if (bus.rsp_valid_o !== 1'b0) $display("FAIL wr_rsp_one_cycle: got %0b exp 0", bus.rsp_valid_o); else n_pass++;
  endtask

  task automatic test_read();
    int unsigned w, l, s, e; logic [7:0] rd; logic er, g, ok;
    slv_rdata = 8'h0A;
    do_cmd(1'b0, 8'h03, 8'h00, w, l, s, e, rd, er, g, ok);
    n_total++; if (g !== 1'b1) $display("FAIL rd_rsp_seen: got %0b exp 1", g); else n_pass++;
    n_total++; if (rd !== 8'h0A) $display("FAIL rd_data: got %0h exp 0a", rd); else n_pass++;
    n_total++; if (er !== 1'b0) $display("FAIL rd_err: got %0b exp 0", er); else n_pass++;
    n_total++; if (ok !== 1'b1) $display("FAIL rd_bus_stable: got %0b exp 1", ok); else n_pass++;
    slv_err = 1'b1;
    do_cmd(1'b0, 8'h05, 8'h00, w, l, s, e, rd, er, g, ok);
    slv_err = 1'b0;
    n_total++; if (er !== 1'b1) $display("FAIL rd_perror: got %0b exp 1", er); else n_pass++;
    n_total++; if (rd !== 8'h00) $display("FAIL rd_perror_data: got %0h exp 0", rd); else n_pass++;
    n_total++; if (w !== 1) $display("FAIL rd_b2b_wait: got %0d exp 1", w); else n_pass++;
  endtask

  task automatic test_timeout();
    int unsigned w, l, s, e; logic [7:0] rd; logic er, g, ok;
    slv_hang = 1'b1; slv_rdata = 8'h77;
    @(negedge clk);
    do_cmd(1'b0, 8'h07, 8'h00, w, l, s, e, rd, er, g, ok);
    slv_hang = 1'b0;
    n_total++; if (g !== 1'b1) $display("FAIL tmo_rsp_seen: got %0b exp 1", g); else n_pass++;
    n_total++; if ({er, rd} !== 9'h100) $display("FAIL tmo_err_rdata: got %0h exp 100", {er, rd}); else n_pass++;
    n_total++; if (e !== 15) $display("FAIL tmo_access_cycles: got %0d exp 15", e); else n_pass++;
    n_total++; if (l !== 17) $display("FAIL tmo_latency: got %0d exp 17", l); else n_pass++;
    do_cmd(1'b1, 8'h08, 8'h3C, w, l, s, e, rd, er, g, ok);
    n_total++; if ({g, er} !== 2'b10) $display("FAIL tmo_next_cmd: got %02b exp 10", {g, er}); else n_pass++;
    n_total++; if (ok !== 1'b1) $display("FAIL tmo_next_bus: got %0b exp 1", ok); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int unsigned w, l, s, e; logic [7:0] rd; logic er, g, ok;
    slv_rdata = 8'hC3;
    @(negedge clk);
    do_cmd(1'b1, 8'h10, 8'h55, w, l, s, e, rd, er, g, ok);
    do_cmd(1'b0, 8'h11, 8'h00, w, l, s, e, rd, er, g, ok);
    n_total++; if (w !== 1) $display("FAIL b2b_wait: got %0d exp 1", w); else n_pass++;
    n_total++; if (rd !== 8'hC3) $display("FAIL b2b_rdata: got %0h exp c3", rd); else n_pass++;
    n_total++; if (l !== 4) $display("FAIL b2b_latency: got %0d exp 4", l); else n_pass++;
  endtask

  task automatic test_intr_basic();
    int unsigned pulses, at_k, got_k;
    @(negedge clk);
    intr_valid = 1'b1; intr_id = 4'd7;
    @(negedge clk);
    n_total++; if (svc_id !== 4'd7) $display("FAIL svc_id_capture: got %0d exp 7", svc_id); else n_pass++;
    n_total++; if (svc_busy !== 1'b1) $display("FAIL svc_busy_set: got %0b exp 1", svc_busy); else n_pass++;
    n_total++; if (svc_count !== 16'd0) $display("FAIL svc_count_pre: got %0d exp 0", svc_count); else n_pass++;
    pulses = 0; at_k = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 2) intr_id = 4'd9;
      if (intr_serviced) begin
        pulses++;
        if (pulses == 1) at_k = k;
      end
    end
    n_total++; if (pulses !== 1) $display("FAIL ack_pulses: got %0d exp 1", pulses); else n_pass++;
    n_total++; if (at_k !== 5) $display("FAIL ack_delay: got %0d exp 5", at_k); else n_pass++;
    n_total++; if (svc_count !== 16'd1) $display("FAIL svc_count_1: got %0d exp 1", svc_count); else n_pass++;
    n_total++; if (svc_id !== 4'd7) $display("FAIL svc_id_hold: got %0d exp 7", svc_id); else n_pass++;
    n_total++; if (svc_busy !== 1'b0) $display("FAIL held_no_retrigger: got %0b exp 0", svc_busy); else n_pass++;
    intr_valid = 1'b0;
    @(negedge clk);
    intr_valid = 1'b1; intr_id = 4'd2;
    @(negedge clk);
    intr_valid = 1'b0;
    n_total++; if ({svc_busy, svc_id} !== 5'h12) $display("FAIL reassert_capture: got %0h exp 12", {svc_busy, svc_id}); else n_pass++;
    got_k = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (intr_serviced && got_k == 0) got_k = k;
    end
    n_total++; if (got_k !== 5) $display("FAIL reassert_ack_delay: got %0d exp 5", got_k); else n_pass++;
    n_total++; if (svc_count !== 16'd2) $display("FAIL svc_count_2: got %0d exp 2", svc_count); else n_pass++;
  endtask

  task automatic test_intr_drop();
    logic seen;
    @(negedge clk); @(negedge clk);
    intr_valid = 1'b1; intr_id = 4'hC;
    @(negedge clk);
    intr_valid = 1'b0; intr_id = 4'h1;
    seen = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (intr_serviced) seen = 1'b1;
    end
    n_total++; if (seen !== 1'b1) $display("FAIL drop_still_acked: got %0b exp 1", seen); else n_pass++;
    n_total++; if (svc_count !== 16'd3) $display("FAIL svc_count_3: got %0d exp 3", svc_count); else n_pass++;
    n_total++; if (svc_id !== 4'hC) $display("FAIL drop_svc_id: got %0h exp c", svc_id); else n_pass++;
  endtask

  task automatic test_concurrent();
    int unsigned w, l, s, e; logic [7:0] rd; logic er, g, ok;
    int unsigned ack_k;
    slv_rdata = 8'h5A;
    @(negedge clk);
    fork
      do_cmd(1'b0, 8'h0F, 8'h00, w, l, s, e, rd, er, g, ok);
      begin
        intr_valid = 1'b1; intr_id = 4'd3;
        @(negedge clk);
        intr_valid = 1'b0;
        ack_k = 0;
        for (int k = 1; k <= 10; k++) begin
          @(negedge clk);
          if (intr_serviced && ack_k == 0) ack_k = k;
        end
      end
    join
    n_total++; if ({g, er, rd} !== 10'h25A) $display("FAIL conc_read: got %0h exp 25a", {g, er, rd}); else n_pass++;
    n_total++; if (l !== 4) $display("FAIL conc_latency: got %0d exp 4", l); else n_pass++;
    n_total++; if (ack_k !== 5) $display("FAIL conc_ack_delay: got %0d exp 5", ack_k); else n_pass++;
    n_total++; if ({svc_count, svc_id} !== 20'h00043) $display("FAIL conc_count_id: got %0h exp 43", {svc_count, svc_id}); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int unsigned strobes;
    slv_hang = 1'b1;
    @(negedge clk);
    bus.cmd_valid_i = 1'b1; bus.cmd_write_i = 1'b0; bus.cmd_addr_i = 8'h22;
    intr_valid = 1'b1; intr_id = 4'd6;
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    @(negedge clk); @(negedge clk);
    n_total++; if ({bus.penable_o, svc_busy} !== 2'b11) $display("FAIL mid_precondition: got %02b exp 11", {bus.penable_o, svc_busy}); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_total++; if ({bus.psel_o, bus.penable_o, bus.cmd_ready_o, bus.rsp_valid_o, bus.rsp_error_o} !== 5'd0)
      $display("FAIL mid_rst_apb_ctl: got %05b exp 00000",
               {bus.psel_o, bus.penable_o, bus.cmd_ready_o, bus.rsp_valid_o, bus.rsp_error_o}); else n_pass++;
    n_total++; if ({bus.paddr_o, bus.pwdata_o, bus.pwrite_o, bus.rsp_rdata_o} !== 25'd0)
      $display("FAIL mid_rst_apb_data: got %0h exp 0", {bus.paddr_o, bus.pwdata_o, bus.pwrite_o, bus.rsp_rdata_o}); else n_pass++;
    n_total++; if ({intr_serviced, svc_busy, svc_id, svc_count} !== 22'd0)
      $display("FAIL mid_rst_intr: got %0h exp 0", {intr_serviced, svc_busy, svc_id, svc_count}); else n_pass++;
    intr_valid = 1'b0; slv_hang = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    strobes = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.rsp_valid_o || intr_serviced) strobes++;
    end
    n_total++; if (strobes !== 0) $display("FAIL mid_rst_no_strobe: got %0d exp 0", strobes); else n_pass++;
    n_total++; if (bus.cmd_ready_o !== 1'b1) $display("FAIL mid_rst_ready: got %0b exp 1", bus.cmd_ready_o); else n_pass++;
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    rst = 1'b1;
    intr_valid = 1'b0; intr_id = '0;
    slv_hang = 1'b0; slv_rdata = '0; slv_err = 1'b0;
    bus.cmd_valid_i = 1'b0; bus.cmd_write_i = 1'b0;
    bus.cmd_addr_i = '0; bus.cmd_wdata_i = '0;
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_back_to_back();
    test_intr_basic();
    test_intr_drop();
    test_concurrent();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
